// File: rtl/status_reg_ext.sv
// status_reg_ext: status register with flag/load/restore priority, LIFO shadow stack, push image and delayed interrupt mask
//   clk, reset (async, active-high)
//   flag_we/flag_in   per-bit flag update
//   load/load_data    whole-register load
//   save/restore      push/pop the shadow stack (both together swap status with the top entry)
//   brk_src           BRK bit value placed into push_image
//   status            registered status; push_image combinational push byte
//   irq_mask_eff      status[I_BIT] after I_DELAY cycles
//   stk_full/stk_empty/stk_err  registered stack flags, stk_err is a one-cycle pulse
module status_reg_ext #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] ZERO_MASK = 8'h30,
  parameter logic [WIDTH-1:0] RESET_VAL = 8'h04,
  parameter int I_BIT = 2,
  parameter int BRK_BIT = 4,
  parameter int UNUSED_BIT = 5,
  parameter int I_DELAY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] flag_we,
  input  logic [WIDTH-1:0] flag_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             save,
  input  logic             restore,
  input  logic             brk_src,
  output logic [WIDTH-1:0] status,
  output logic [WIDTH-1:0] push_image,
  output logic             irq_mask_eff,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] KEEP = ~ZERO_MASK;
  logic [WIDTH-1:0] r_status;
  logic [WIDTH-1:0] r_stk [DEPTH];
  logic [CW-1:0]    r_cnt;
  logic             r_full, r_empty, r_err;
  logic             w_empty, w_full, w_rvalid, w_swap, w_push, w_pop, w_err;
  logic [AW-1:0]    w_top_idx, w_wr_idx;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_status_nxt;
  always_comb begin
    w_empty      = r_cnt == '0;
    w_full       = r_cnt == CW'(DEPTH);
    w_rvalid     = restore & ~w_empty;
    w_swap       = save & w_rvalid;
    // save+restore on an empty stack degrades to a plain push
    w_push       = save & ~w_rvalid & ~w_full;
    w_pop        = w_rvalid & ~save;
    w_err        = (save & ~w_rvalid & w_full) | (restore & w_empty);
    w_top_idx    = AW'(r_cnt - CW'(1));
    w_wr_idx     = w_swap ? w_top_idx : AW'(r_cnt);
    w_cnt_nxt    = w_push ? r_cnt + CW'(1) : w_pop ? r_cnt - CW'(1) : r_cnt;
    w_status_nxt = KEEP & (w_rvalid ? r_stk[w_top_idx] :
                           load     ? load_data :
                           (r_status & ~flag_we) | (flag_in & flag_we));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_status <= RESET_VAL & KEEP;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_status <= w_status_nxt;
      r_cnt    <= w_cnt_nxt;
      r_full   <= w_cnt_nxt == CW'(DEPTH);
      r_empty  <= w_cnt_nxt == '0;
      r_err    <= w_err;
    end
  end
  // Entries hold the pre-edge status, which is already masked
  always_ff @(posedge clk) begin
    if (~reset & (w_push | w_swap)) r_stk[w_wr_idx] <= r_status;
  end
  always_comb begin
    push_image             = r_status;
    push_image[UNUSED_BIT] = 1'b1;
    push_image[BRK_BIT]    = brk_src;
  end
  generate
    if (I_DELAY == 0) begin : g_nodly
      assign irq_mask_eff = r_status[I_BIT];
    end else begin : g_dly
      logic [I_DELAY-1:0] r_irq;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_irq <= {I_DELAY{RESET_VAL[I_BIT]}};
        else       r_irq <= I_DELAY'({r_irq, r_status[I_BIT]});
      end
      assign irq_mask_eff = r_irq[I_DELAY-1];
    end
  endgenerate
  assign status    = r_status;
  assign stk_full  = r_full;
  assign stk_empty = r_empty;
  assign stk_err   = r_err;
endmodule

// File: tb/tb_status_reg_ext.sv
// tb_status_reg_ext: directed self-checking bench for status_reg_ext
module tb_status_reg_ext;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] flag_we = '0, flag_in = '0, load_data = '0;
  logic       load = 1'b0, save = 1'b0, restore = 1'b0, brk_src = 1'b0;
  logic [7:0] status, push_image;
  logic       irq_mask_eff, stk_full, stk_empty, stk_err;
  int         checks = 0;
  int         errors = 0;

  status_reg_ext #(.I_DELAY(2)) dut (
    .clk(clk), .reset(reset), .flag_we(flag_we), .flag_in(flag_in),
    .load(load), .load_data(load_data), .save(save), .restore(restore),
    .brk_src(brk_src), .status(status), .push_image(push_image),
    .irq_mask_eff(irq_mask_eff), .stk_full(stk_full), .stk_empty(stk_empty),
    .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #1;
    chk("rst_status", status, 8'h04);
    chk("rst_empty", {7'd0, stk_empty}, 8'h01);
    chk("rst_full", {7'd0, stk_full}, 8'h00);
    chk("rst_err", {7'd0, stk_err}, 8'h00);
    chk("rst_irq", {7'd0, irq_mask_eff}, 8'h01);
    step();
    reset = 1'b0;
    step();
    chk("idle_status", status, 8'h04);
    // load with zero mask, push image
    load = 1'b1; load_data = 8'hFF;
    step();
    load = 1'b0;
    chk("load_ff", status, 8'hCF);
    brk_src = 1'b1;
    #1 chk("img_brk1", push_image, 8'hFF);
    brk_src = 1'b0;
    #1 chk("img_brk0", push_image, 8'hEF);
    // per-bit flag writes
    load = 1'b1; load_data = 8'h00;
    step();
    load = 1'b0;
    chk("load_00", status, 8'h00);
    flag_we = 8'h81; flag_in = 8'hFF;
    step();
    chk("flag_set", status, 8'h81);
    flag_we = 8'h01; flag_in = 8'h00;
    step();
    chk("flag_clr", status, 8'h80);
    flag_we = 8'h30; flag_in = 8'hFF;
    step();
    flag_we = 8'h00; flag_in = 8'h00;
    chk("flag_zmask", status, 8'h80);
    // save captures pre-edge status despite a same-cycle load
    load = 1'b1; load_data = 8'h41;
    step();
    chk("load_41", status, 8'h41);
    save = 1'b1; load_data = 8'h00;
    step();
    save = 1'b0; load = 1'b0;
    chk("save_load", status, 8'h00);
    chk("save_nempty", {7'd0, stk_empty}, 8'h00);
    restore = 1'b1;
    step();
    restore = 1'b0;
    chk("restore_41", status, 8'h41);
    chk("restore_empty", {7'd0, stk_empty}, 8'h01);
    chk("restore_noerr", {7'd0, stk_err}, 8'h00);
    // irq delay of two cycles
    load = 1'b1; load_data = 8'h04;
    step();
    load = 1'b0;
    step();
    step();
    chk("irq_up", {7'd0, irq_mask_eff}, 8'h01);
    load = 1'b1; load_data = 8'h00;
    step();
    load = 1'b0;
    chk("irq_n0", {7'd0, irq_mask_eff}, 8'h01);
    step();
    chk("irq_n1", {7'd0, irq_mask_eff}, 8'h01);
    step();
    chk("irq_n2", {7'd0, irq_mask_eff}, 8'h00);
    load = 1'b1; load_data = 8'h04;
    step();
    load = 1'b0;
    step();
    step();
    chk("irq_up2", {7'd0, irq_mask_eff}, 8'h01);
    // reset at n+1 discards the pending clear and overrides inputs
    load = 1'b1; load_data = 8'h00;
    step();
    load = 1'b0;
    step();
    reset = 1'b1; save = 1'b1; load = 1'b1; load_data = 8'hFF;
    #1;
    chk("mid_rst_status", status, 8'h04);
    chk("mid_rst_irq", {7'd0, irq_mask_eff}, 8'h01);
    step();
    reset = 1'b0; save = 1'b0; load = 1'b0;
    chk("mid_rst_empty", {7'd0, stk_empty}, 8'h01);
    step();
    chk("post_rst_irq", {7'd0, irq_mask_eff}, 8'h01);
    chk("post_rst_status", status, 8'h04);
    // fill the stack: pushes 01, 02, 03, C4; status ends at 80
    load = 1'b1; load_data = 8'h01;
    step();
    save = 1'b1; load_data = 8'h02;
    step();
    load_data = 8'h03;
    step();
    load_data = 8'hC4;
    step();
    chk("fill3_full", {7'd0, stk_full}, 8'h00);
    load_data = 8'h80;
    step();
    load = 1'b0;
    chk("fill4_full", {7'd0, stk_full}, 8'h01);
    chk("fill4_err", {7'd0, stk_err}, 8'h00);
    chk("fill4_status", status, 8'h80);
    step();
    save = 1'b0;
    chk("ovf_err", {7'd0, stk_err}, 8'h01);
    chk("ovf_status", status, 8'h80);
    step();
    chk("ovf_err_clr", {7'd0, stk_err}, 8'h00);
    // swap while full: status<-C4, top<-80
    save = 1'b1; restore = 1'b1;
    step();
    save = 1'b0;
    chk("swap_status", status, 8'hC4);
    chk("swap_full", {7'd0, stk_full}, 8'h01);
    chk("swap_err", {7'd0, stk_err}, 8'h00);
    load = 1'b1; load_data = 8'hFF;
    step();
    load = 1'b0;
    chk("pop1", status, 8'h80);
    step();
    chk("pop2", status, 8'h03);
    step();
    chk("pop3", status, 8'h02);
    step();
    restore = 1'b0;
    chk("pop4", status, 8'h01);
    chk("pop4_empty", {7'd0, stk_empty}, 8'h01);
    // restore while empty falls through to flag_we
    load = 1'b1; load_data = 8'h00;
    step();
    load = 1'b0;
    restore = 1'b1; flag_we = 8'h01; flag_in = 8'h01;
    step();
    restore = 1'b0; flag_we = 8'h00; flag_in = 8'h00;
    chk("unf_status", status, 8'h01);
    chk("unf_err", {7'd0, stk_err}, 8'h01);
    chk("unf_empty", {7'd0, stk_empty}, 8'h01);
    step();
    chk("unf_err_clr", {7'd0, stk_err}, 8'h00);
    // save+restore while empty acts as save with an error pulse
    save = 1'b1; restore = 1'b1;
    step();
    save = 1'b0; restore = 1'b0;
    chk("sr_empty_nempty", {7'd0, stk_empty}, 8'h00);
    chk("sr_empty_err", {7'd0, stk_err}, 8'h01);
    chk("sr_empty_status", status, 8'h01);
    load = 1'b1; load_data = 8'h00;
    step();
    load = 1'b0;
    restore = 1'b1;
    step();
    restore = 1'b0;
    chk("sr_empty_pop", status, 8'h01);
    chk("sr_empty_final", {7'd0, stk_empty}, 8'h01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
